// File: rtl/bp_me_pkg.sv
// Shared BedRock memory-engine arbiter types: arbiter FSM states and
// requester count, plus a helper that maps a requester id to its lock state.
package bp_me_pkg;

  localparam int bp_me_arb_num_req_gp = 2;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_lock0 = 2'd1,
    e_lock1 = 2'd2
  } bp_me_arb_state_e;

  // Lock state that keeps requester id on the memory port until its last beat.
  function automatic bp_me_arb_state_e bp_me_arb_lock_state(input logic id);
    return id ? e_lock1 : e_lock0;
  endfunction

endpackage

// File: rtl/bp_me_arb_order_fifo.sv
// In-order grant record for the memory command arbiter: one bit per
// outstanding command naming the requester that owns the next response.
// Push and pop may happen in the same cycle; a pop while full frees the slot
// only on the following cycle because ready_o comes straight from the count.
module bp_me_arb_order_fifo #(
  parameter int els_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic data_i,
  input  logic v_i,
  output logic ready_o,
  output logic data_o,
  output logic v_o,
  input  logic yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic [els_p-1:0]    mem_q, mem_d;
  logic                push, pop;

  assign ready_o = (count_q != cnt_w_lp'(els_p));
  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[rptr_q];

  // Next pointers, count and storage; pointers wrap naturally (depth is 2^n).
  always_comb begin
    push    = v_i & ready_o;
    pop     = yumi_i & v_o;
    wptr_d  = wptr_q + ptr_w_lp'(push);
    rptr_d  = rptr_q + ptr_w_lp'(pop);
    count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    mem_d   = mem_q;
    if (push) mem_d[wptr_q] = data_i;
  end

  // Control state: cleared asynchronously so the FIFO reads empty at once.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array.
  // NOTE: storage is deliberately not reset; an entry is only read while
  // count_q says it holds a valid record, so its reset value never matters.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_me_mem_cmd_arbiter.sv
// Two-to-one BedRock stream arbiter for the memory command/response channel.
// Commands are granted round-robin and locked for a whole burst; responses
// return in command order and are steered by an in-order grant record.
// Define BP_ME_ARB_FIXED_PRIO_EN to make requester 0 always win when idle
// (the round-robin pointer is then not built).
module bp_me_mem_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int outstanding_p  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [2*header_width_p-1:0] req_header_i,
  input  logic [2*data_width_p-1:0]   req_data_i,
  input  logic [1:0]                  req_v_i,
  input  logic [1:0]                  req_last_i,
  output logic [1:0]                  req_ready_and_o,
  output logic [header_width_p-1:0]   mem_cmd_header_o,
  output logic [data_width_p-1:0]     mem_cmd_data_o,
  output logic                        mem_cmd_v_o,
  output logic                        mem_cmd_last_o,
  input  logic                        mem_cmd_ready_and_i,
  input  logic [header_width_p-1:0]   mem_resp_header_i,
  input  logic [data_width_p-1:0]     mem_resp_data_i,
  input  logic                        mem_resp_v_i,
  input  logic                        mem_resp_last_i,
  output logic                        mem_resp_ready_and_o,
  output logic [header_width_p-1:0]   resp_header_o,
  output logic [data_width_p-1:0]     resp_data_o,
  output logic [1:0]                  resp_v_o,
  output logic                        resp_last_o,
  input  logic [1:0]                  resp_ready_and_i
);

  bp_me_arb_state_e state_q, state_d;
`ifndef BP_ME_ARB_FIXED_PRIO_EN
  logic rr_q, rr_d;
`endif
  logic winner, grant_id, grant_v, cmd_accept;
  logic fifo_ready, fifo_v, fifo_head, fifo_push, fifo_pop;

  // Idle-state winner among the valid requesters.
  always_comb begin
`ifdef BP_ME_ARB_FIXED_PRIO_EN
    winner = ~req_v_i[0];
`else
    winner = req_v_i[rr_q] ? rr_q : ~rr_q;
`endif
  end

  // Grant selection, burst locking and round-robin update.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
`ifndef BP_ME_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    grant_id   = winner;
    grant_v    = 1'b0;
    cmd_accept = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      e_idle:  begin grant_id = winner; grant_v = (|req_v_i) & fifo_ready; end
      e_lock0: begin grant_id = 1'b0;   grant_v = 1'b1;                    end
      e_lock1: begin grant_id = 1'b1;   grant_v = 1'b1;                    end
      default: ;
    endcase
    // Reset silences the command side immediately, even mid-burst.
    grant_v    = grant_v & reset_n_i;
    cmd_accept = grant_v & req_v_i[grant_id] & mem_cmd_ready_and_i;
    if (cmd_accept) begin
      if (state_q == e_idle) fifo_push = 1'b1;
      if (req_last_i[grant_id]) begin
        state_d = e_idle;
`ifndef BP_ME_ARB_FIXED_PRIO_EN
        rr_d    = ~grant_id;
`endif
      end else begin
        state_d = bp_me_arb_lock_state(grant_id);
      end
    end
  end

  // Arbiter state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and updates together at the clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
`ifndef BP_ME_ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifndef BP_ME_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Command path: zero-latency mux of the granted requester.
  assign mem_cmd_v_o      = grant_v & req_v_i[grant_id];
  assign mem_cmd_last_o   = req_last_i[grant_id];
  assign mem_cmd_header_o = grant_id ? req_header_i[2*header_width_p-1:header_width_p]
                                     : req_header_i[header_width_p-1:0];
  assign mem_cmd_data_o   = grant_id ? req_data_i[2*data_width_p-1:data_width_p]
                                     : req_data_i[data_width_p-1:0];
  assign req_ready_and_o  = {2{grant_v & mem_cmd_ready_and_i}} & (grant_id ? 2'b10 : 2'b01);

  // Response path: steer to the oldest recorded requester; hold if no record.
  assign resp_header_o        = mem_resp_header_i;
  assign resp_data_o          = mem_resp_data_i;
  assign resp_last_o          = mem_resp_last_i;
  assign resp_v_o             = {2{mem_resp_v_i & fifo_v}} & (fifo_head ? 2'b10 : 2'b01);
  assign mem_resp_ready_and_o = fifo_v & resp_ready_and_i[fifo_head];
  assign fifo_pop             = mem_resp_v_i & mem_resp_ready_and_o & mem_resp_last_i;

  bp_me_arb_order_fifo #(
    .els_p(outstanding_p)
  ) u_order_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   (grant_id),
    .v_i      (fifo_push),
    .ready_o  (fifo_ready),
    .data_o   (fifo_head),
    .v_o      (fifo_v),
    .yumi_i   (fifo_pop)
  );

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

Two-to-one BedRock stream arbiter for the memory command/response channel. It lets two cache engines share one memory port: typically the I$ UCE and a second UCE or test requester in the FE/ME testbenches and single-core tiles. Commands are granted round-robin and locked for a whole burst (through `last`). Responses are steered back to the originating requester using an in-order grant-record FIFO. The downstream memory must return responses in command order.

## Interface
Parameters:
- header_width_p, 64, BedRock mem header width (mem_header_width_lp at instantiation)
- data_width_p, 64, stream beat width (l2_data_width_p)
- outstanding_p, 4, max in-flight commands; power of two, ≥2

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- req_header_i  in  2×header_width_p  per-requester cmd header
- req_data_i  in  2×data_width_p  per-requester cmd beat
- req_v_i  in  2  cmd beat valid
- req_last_i  in  2  final beat of cmd
- req_ready_and_o  out  2  cmd beat accepted when v&ready
- mem_cmd_header_o  out  header_width_p  granted header
- mem_cmd_data_o  out  data_width_p  granted beat
- mem_cmd_v_o  out  1  cmd valid
- mem_cmd_last_o  out  1  cmd last
- mem_cmd_ready_and_i  in  1  downstream ready
- mem_resp_header_i  in  header_width_p  resp header
- mem_resp_data_i  in  data_width_p  resp beat
- mem_resp_v_i  in  1  resp valid
- mem_resp_last_i  in  1  resp last
- mem_resp_ready_and_o  out  1  resp accepted
- resp_header_o  out  header_width_p  broadcast resp header
- resp_data_o  out  data_width_p  broadcast resp beat
- resp_v_o  out  2  per-requester resp valid
- resp_last_o  out  1  resp last
- resp_ready_and_i  in  2  per-requester resp ready

## Operation
- States: e_idle, e_lock0, e_lock1.
- e_idle:
  - Winner is chosen from req_v_i using round-robin pointer rr_r. Requester rr_r has priority on a tie.
  - Winner is presented downstream only if the order FIFO is not full.
  - Accepted beat with last=1: stay in e_idle, rr_r ← ~winner.
  - Accepted beat with last=0: go to e_lockN.
- e_lockN:
  - Only requester N is muxed out. The full check is ignored because the entry was pushed on the first beat.
  - Accepted last beat: go to e_idle, rr_r ← ~N.
- Order FIFO:
  - Push the granted requester id on the first accepted beat of each command.
  - Pop on an accepted resp beat with mem_resp_last_i=1.
- Response path:
  - resp_v_o[h] = mem_resp_v_i & fifo_v & (head==h); resp_v_o for the non-head requester is 0.
  - mem_resp_ready_and_o = fifo_v & resp_ready_and_i[head].
  - Header, data and last are broadcast to both requesters.
- Boundaries:
  - FIFO full in e_idle: no grant, both req_ready_and_o=0.
  - FIFO empty: mem_resp_ready_and_o=0 and resp_v_o=0. A response with no record is held, not dropped.
  - Simultaneous push and pop, including when full: both take effect, count unchanged. A pop while full frees the slot on the next cycle, not combinationally.
  - Reset mid-burst or mid-response: immediately e_idle, rr_r=0, FIFO empty. Partial bursts are discarded.
- Count register is $clog2(outstanding_p+1) bits. Pointers are $clog2(outstanding_p) bits and wrap naturally.

## Timing
- Command and response paths are combinational pass-through: zero added latency, one beat per cycle.
- Grant, state, rr_r and the FIFO update on posedge clk_i.
- Reset values: state e_idle, rr_r=0, FIFO count 0.
- Under reset with inputs idle, all outputs are 0: mem_cmd_v_o=0, req_ready_and_o=0, resp_v_o=0, mem_resp_ready_and_o=0.
- A requester may deassert req_v_i before acceptance only in e_idle. In e_lockN, v must hold until last is accepted.
- Outputs must not depend combinationally on req_v_i of the non-granted requester while locked.

## Configuration
- BP_ME_ARB_FIXED_PRIO_EN defined: requester 0 always wins in e_idle, and rr_r is not instantiated.
- BP_ME_ARB_FIXED_PRIO_EN undefined: round-robin as above.
- Burst locking and response routing are identical in both modes.

## Structure
- Shared package bp_me_pkg holds:
  - bp_me_arb_state_e (e_idle, e_lock0, e_lock1)
  - bp_me_arb_num_req_gp = 2
- Sub-module bp_me_arb_order_fifo:
  - 1-bit wide, outstanding_p deep, async active-low reset, ready_o/v_o/yumi_i interface.
  - Supports push and pop in the same cycle.

## Test plan
- Single-beat reads from both requesters in the same cycle, rr_r=0: req0 granted at cycle 0, req1 at cycle 1, rr_r=0 after both; responses A then B go to resp_v_o[0] then resp_v_o[1].
- req0 4-beat write with req1 valid throughout: req1 is blocked until req0's last beat is accepted, then granted on the next cycle; mem_cmd_last_o is high on exactly beat 4.
- 4 commands outstanding with no responses: 5th command stalls (req_ready_and_o=0); 1 response pop lets it issue the following cycle.
- 2-beat response with resp_ready_and_i[head]=0 for 3 cycles: mem_resp_ready_and_o is low for those cycles, nothing is dropped, and the pop happens on the last beat only.
- reset_n_i asserted mid-burst at beat 2 of 4: outputs go to 0 asynchronously; after release, state is e_idle, FIFO empty, and a new req1 command is granted first (rr_r=0 but req0 idle).
- With BP_ME_ARB_FIXED_PRIO_EN, both requesters continuously valid with single-beat commands: req0 wins every cycle and req1 is never granted.
